// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master and its users.
package spi_pkg;

   localparam int SPI_WORD_W  = 32;
   localparam int SPI_CLK_DIV = 4;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT_HI,
      SHIFT_LO,
      TRAIL
   } spi_state_t;

endpackage

// File: rtl/spi_if.sv
// Command handshake plus SPI pins of one master link; "slave" is the view of everything around the master.
interface spi_if
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WORD_W
);
   logic             start;
   logic [WIDTH-1:0] tx_data;
   logic             ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             sck;
   logic             mosi;
   logic             miso;
   logic             cs_n;

   modport master (
      input  start, tx_data, miso,
      output ready, rx_data, rx_valid, sck, mosi, cs_n
   );

   modport slave (
      output start, tx_data, miso,
      input  ready, rx_data, rx_valid, sck, mosi, cs_n
   );
endinterface

// File: rtl/spi_sck_gen.sv
// Half-period timer: strobes half_done every HALF enabled cycles, restarting on each strobe.
module spi_sck_gen
   import spi_pkg::*;
#(
   parameter int HALF = SPI_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic half_done
);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The FSM only changes state on half_done, so restarting here restarts every state's dwell.
   assign half_done = enable && (cnt_q == CNT_W'(HALF - 1));

   // NOTE: give every always_comb output a default first so no path can infer a latch.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!enable || half_done) cnt_d = '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: shifts one WIDTH-bit word out on mosi MSB first while capturing miso.
module spi_master
   import spi_pkg::*;
#(
   parameter int WIDTH   = SPI_WORD_W,
   parameter int CLK_DIV = SPI_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   spi_if.master bus
);
   localparam int BIT_W = $clog2(WIDTH);

   spi_state_t       state_q;
   logic [WIDTH-1:0] tx_q;
   logic [WIDTH-1:0] rx_q;
   logic [BIT_W-1:0] bit_cnt_q;
   logic [WIDTH-1:0] rx_data_q;
   logic             rx_valid_q;
   logic             ready_q;
   logic             cs_n_q;
   logic             sck_q;
   logic             mosi_q;
   logic             sck_en;
   logic             half_done;

   assign sck_en = (state_q != IDLE);

   spi_sck_gen #(.HALF(CLK_DIV)) u_sck_gen (
      .clk       (clk),
      .reset     (reset),
      .enable    (sck_en),
      .half_done (half_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_q       <= '0;
         rx_q       <= '0;
         bit_cnt_q  <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ready_q    <= 1'b1;
         cs_n_q     <= 1'b1;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // Skipping the completion cycle keeps cs_n high for two cycles between words.
               if (bus.start && !rx_valid_q) begin
                  tx_q      <= bus.tx_data;
                  bit_cnt_q <= BIT_W'(WIDTH - 1);
                  mosi_q    <= bus.tx_data[WIDTH-1];
                  cs_n_q    <= 1'b0;
                  ready_q   <= 1'b0;
                  state_q   <= LEAD;
               end
            end
            LEAD: begin
               if (half_done) begin
                  sck_q   <= 1'b1;
                  rx_q    <= {rx_q[WIDTH-2:0], bus.miso};
                  state_q <= SHIFT_HI;
               end
            end
            SHIFT_HI: begin
               if (half_done) begin
                  sck_q <= 1'b0;
                  // The last falling edge leads straight into the trailing cs_n hold.
                  if (bit_cnt_q == '0) begin
                     state_q <= TRAIL;
                  end else begin
                     tx_q    <= tx_q << 1;
                     mosi_q  <= tx_q[WIDTH-2];
                     state_q <= SHIFT_LO;
                  end
               end
            end
            SHIFT_LO: begin
               if (half_done) begin
                  sck_q     <= 1'b1;
                  rx_q      <= {rx_q[WIDTH-2:0], bus.miso};
                  bit_cnt_q <= bit_cnt_q - 1'b1;
                  state_q   <= SHIFT_HI;
               end
            end
            TRAIL: begin
               if (half_done) begin
                  cs_n_q     <= 1'b1;
                  ready_q    <= 1'b1;
                  mosi_q     <= 1'b0;
                  rx_data_q  <= rx_q;
                  rx_valid_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready    = ready_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.sck      = sck_q;
   assign bus.mosi     = mosi_q;
   assign bus.cs_n     = cs_n_q;
endmodule
